led_shift_driver: RTL and testbench
===================================

LED_SHIFT_DRIVER -- requirements
Module: led_shift_driver

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per ser_clk half-period; legal values 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 led_in  input  16  parallel LED pattern from bound_flasher LED output; bit 15 = leftmost LED.
REQ-005 ser_clk  output  1  serial shift clock to external 16-bit shift-register chain; data sampled externally on its rising edge.
REQ-006 ser_data  output  1  serial data, MSB (led_in[15]) first.
REQ-007 ser_latch  output  1  storage-register latch pulse, active-high.
REQ-008 busy  output  1  high while a frame (shift plus latch) is in progress.

Function
REQ-009 The block SHALL register every output; no output shall be driven combinationally from led_in.
REQ-010 The block SHALL hold a 16-bit shadow register holding the last pattern sent, and SHALL implement states IDLE, SHIFT and LATCH.
REQ-011 In IDLE, when led_in != shadow on a clk edge, the block SHALL start a frame on that edge:
- capture led_in into the shift register and into shadow
- enter SHIFT; set busy=1, ser_clk=0, ser_data=led_in[15]
REQ-012 In IDLE, when led_in == shadow, the block SHALL remain in IDLE with all outputs 0.
REQ-013 In SHIFT, each bit SHALL occupy 2*CLK_DIV cycles: ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-014 ser_data SHALL change only on the edge where ser_clk goes low (or at frame start), so data is stable CLK_DIV cycles before and after each ser_clk rising edge.
REQ-015 Bits SHALL be sent in order 15 down to 0; a 4-bit counter SHALL count bits and SHALL NOT wrap within a frame.
REQ-016 After the high phase of bit 0 ends, the block SHALL drive ser_clk=0 and ser_data=0, and enter LATCH with ser_latch=1.
REQ-017 ser_latch SHALL stay high for exactly CLK_DIV cycles; the block SHALL then drive ser_latch=0 and busy=0 and return to IDLE.
REQ-018 Frame length SHALL be exactly 33*CLK_DIV cycles of busy=1 (66 cycles for CLK_DIV=2).
REQ-019 Successive frames SHALL be separated by at least one IDLE cycle with busy=0.
REQ-020 Changes on led_in during SHIFT or LATCH SHALL NOT alter the frame in progress; the comparison in the following IDLE cycle SHALL pick up the newest value, so only the latest pattern is sent and intermediate values are dropped.
REQ-021 Exactly 16 ser_clk rising edges and one ser_latch pulse SHALL occur per frame.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force: state IDLE, shadow=0, shift register=0, bit and divide counters=0, and ser_clk, ser_data, ser_latch, busy all 0.
REQ-023 An assertion of rst_n mid-frame SHALL abort the frame immediately, with no latch pulse.
REQ-024 After rst_n deasserts, the first edge with led_in != 0 SHALL start a new frame; led_in=0 SHALL produce no frame.

Verification (clk period 10 ns, CLK_DIV=2)
REQ-025 Reset with led_in=16'h0000, then release -> no frame: busy, ser_clk and ser_latch stay 0 for 200 cycles.
REQ-026 led_in=16'h8001 after reset -> busy high 66 cycles; bits sampled at ser_clk rising edges = 1,0x14,1; one 2-cycle ser_latch pulse; busy then low.
REQ-027 led_in steps 16'h0001->16'h0003->16'h0007 at 10-cycle intervals during a frame -> frame 1 sends 16'h0001; frame 2 starts after exactly one IDLE cycle and sends 16'h0007; 16'h0003 is never sent.
REQ-028 Drive bound_flasher LED output into led_in under rst_n pulses and flick=1/0 as in the system bench -> every ser_latch pulse shows a captured word equal to LED at frame start, and the final latched word equals the final LED value.
REQ-029 rst_n asserted at cycle 30 of a frame for 6 ns -> all outputs 0 within that cycle, no ser_latch pulse; after release the unchanged nonzero led_in is resent in full.
REQ-030 Same led_in held for 500 cycles after one frame -> exactly one frame; no further ser_clk activity.

Source files
------------

// File: rtl/led_shift_driver.sv
// Serialises a 16-bit LED pattern into an external shift-register chain whenever it changes.
// A frame shifts 16 bits MSB first, pulses the storage latch, then returns to idle.
module led_shift_driver #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] led_in,
    output logic        ser_clk,
    output logic        ser_data,
    output logic        ser_latch,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, next_state;
    logic [15:0] shadow, shadow_d;
    logic [15:0] shift_reg, shift_d;
    logic [3:0]  bit_cnt, bit_d;
    logic [7:0]  div_cnt, div_d;
    logic        ser_clk_d, ser_data_d, ser_latch_d, busy_d;
    logic        div_done, last_bit, changed;

    assign div_done  = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == 4'd15);
    assign changed   = (led_in != shadow);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (changed) next_state = SHIFT;
            SHIFT:   if (div_done && ser_clk && last_bit) next_state = LATCH;
            LATCH:   if (div_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of every registered output and of the datapath; outputs are
    // the flops below, so nothing reaches a pin combinationally from led_in.
    always_comb begin
        ser_clk_d   = ser_clk;
        ser_data_d  = ser_data;
        ser_latch_d = ser_latch;
        busy_d      = busy;
        shift_d     = shift_reg;
        shadow_d    = shadow;
        bit_d       = bit_cnt;
        div_d       = div_cnt;
        case (state)
            IDLE: begin
                ser_clk_d   = 1'b0;
                ser_data_d  = 1'b0;
                ser_latch_d = 1'b0;
                busy_d      = 1'b0;
                bit_d       = 4'd0;
                div_d       = 8'd0;
                if (changed) begin
                    shift_d    = led_in;
                    shadow_d   = led_in;
                    busy_d     = 1'b1;
                    ser_data_d = led_in[15];
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_d = 8'd0;
                    if (!ser_clk) begin
                        ser_clk_d = 1'b1;
                    end else if (last_bit) begin
                        ser_clk_d   = 1'b0;
                        ser_data_d  = 1'b0;
                        ser_latch_d = 1'b1;
                    end else begin
                        // Data only moves as the clock falls, mid-way between rising edges.
                        ser_clk_d  = 1'b0;
                        ser_data_d = shift_reg[14];
                        shift_d    = {shift_reg[14:0], 1'b0};
                        bit_d      = bit_cnt + 4'd1;
                    end
                end else begin
                    div_d = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (div_done) begin
                    div_d       = 8'd0;
                    ser_latch_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    div_d = div_cnt + 8'd1;
                end
            end
            default: begin
                ser_clk_d   = 1'b0;
                ser_data_d  = 1'b0;
                ser_latch_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            shift_reg <= 16'd0;
            shadow    <= 16'd0;
            bit_cnt   <= 4'd0;
            div_cnt   <= 8'd0;
        end else begin
            ser_clk   <= ser_clk_d;
            ser_data  <= ser_data_d;
            ser_latch <= ser_latch_d;
            busy      <= busy_d;
            shift_reg <= shift_d;
            shadow    <= shadow_d;
            bit_cnt   <= bit_d;
            div_cnt   <= div_d;
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: a negedge monitor rebuilds each frame from the
// serial pins, and the stimulus sequence compares those frames against expected words.
module tb_led_shift_driver;

    localparam int CLK_DIV = 2;
    localparam int FRAME   = 33 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] led_in = 16'h0000;
    logic        ser_clk, ser_data, ser_latch, busy;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    led_shift_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_in    (led_in),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .ser_latch (ser_latch),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] start;
        int          rises;
        int          latch_len;
        int          busy_len;
        int          gap;
    } frame_t;

    frame_t      rec[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rd = 0;
    int          rst_pulses = 0;
    logic [15:0] led_at_edge = 16'h0000;

    always @(posedge clk) led_at_edge = led_in;

    // Monitor: records each completed frame; frames cut short by reset are discarded.
    int     seen_rst = 0;
    int     cyc = 0;
    int     last_end = 0;
    int     starts = 0;
    bit     prev_busy = 1'b0;
    bit     prev_sclk = 1'b0;
    bit     open = 1'b0;
    frame_t cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n || seen_rst != rst_pulses) begin
            seen_rst  = rst_pulses;
            open      = 1'b0;
            prev_busy = busy;
            prev_sclk = ser_clk;
        end else begin
            if (busy && !prev_busy) begin
                open          = 1'b1;
                starts++;
                cur.word      = 16'h0000;
                cur.start     = led_at_edge;
                cur.rises     = 0;
                cur.latch_len = 0;
                cur.busy_len  = 0;
                cur.gap       = cyc - last_end;
            end
            if (open) begin
                if (busy) cur.busy_len++;
                if (ser_clk && !prev_sclk) begin
                    cur.word = {cur.word[14:0], ser_data};
                    cur.rises++;
                end
                if (ser_latch) cur.latch_len++;
                if (!busy && prev_busy) begin
                    rec.push_back(cur);
                    open     = 1'b0;
                    last_end = cyc;
                end
            end
            prev_busy = busy;
            prev_sclk = ser_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_recs(input int n, input int budget);
        int i;
        i = 0;
        while (rec.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("frame_done_in_budget", 32'(rec.size() >= n), 32'd1);
    endtask

    // use_start=1 compares each frame to led_in at its start edge, otherwise to exp_q.
    task automatic drain(input bit use_start);
        frame_t f;
        if (!use_start) chk("frame_count", 32'(rec.size() - rd), 32'(exp_q.size()));
        while (rd < rec.size()) begin
            f = rec[rd];
            rd++;
            if (use_start) begin
                chk("word_vs_start", 32'(f.word), 32'(f.start));
            end else if (exp_q.size() > 0) begin
                chk("word", 32'(f.word), 32'(exp_q.pop_front()));
            end
            chk("ser_clk_rises", 32'(f.rises), 32'd16);
            chk("latch_len", 32'(f.latch_len), 32'(CLK_DIV));
            chk("busy_len", 32'(f.busy_len), 32'(FRAME));
        end
        if (!use_start) exp_q.delete();
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        rst_pulses++;
        #1;
        chk("rst_ser_clk", 32'(ser_clk), 32'd0);
        chk("rst_ser_data", 32'(ser_data), 32'd0);
        chk("rst_ser_latch", 32'(ser_latch), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        #5 rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        int i;

        // Reset with a zero pattern: nothing is sent.
        repeat (3) @(negedge clk);
        chk("reset_ser_clk", 32'(ser_clk), 32'd0);
        chk("reset_ser_data", 32'(ser_data), 32'd0);
        chk("reset_ser_latch", 32'(ser_latch), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("zero_no_frame_starts", 32'(starts), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);

        // Single frame with both end bits set.
        led_in = 16'h8001;
        exp_q.push_back(16'h8001);
        wait_recs(1, 200);
        drain(1'b0);
        chk("idle_after_8001", 32'(busy), 32'd0);

        // Pattern changes during a frame: only the newest is sent next.
        repeat (5) @(negedge clk);
        led_in = 16'h0001;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0007);
        repeat (10) @(negedge clk);
        led_in = 16'h0003;
        repeat (10) @(negedge clk);
        led_in = 16'h0007;
        wait_recs(3, 300);
        drain(1'b0);
        chk("inter_frame_gap", 32'(rec[rec.size()-1].gap), 32'd1);

        // Holding the same pattern produces no further frames.
        s0 = starts;
        repeat (500) @(negedge clk);
        chk("hold_no_new_frame", 32'(starts), 32'(s0));
        chk("hold_ser_clk_low", 32'(ser_clk), 32'd0);

        // Reset around cycle 30 of a frame aborts it; the pattern is then resent.
        led_in = 16'h1234;
        exp_q.push_back(16'h1234);
        s0 = starts;
        i = 0;
        while (starts == s0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("abort_frame_started", 32'(starts - s0), 32'd1);
        repeat (29) @(negedge clk);
        pulse_reset();
        wait_recs(rd + 1, 300);
        drain(1'b0);

        // Random pattern stream with two asynchronous resets.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            led_in = 16'($urandom_range(1, 65535));
            repeat ($urandom_range(3, 90)) @(negedge clk);
            if (k == 5 || k == 9) pulse_reset();
        end
        repeat (160) @(negedge clk);
        drain(1'b1);
        chk("final_latched_word", 32'(rec[rec.size()-1].word), 32'(led_in));
        chk("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
